// File: rtl/rv32imac_lsu.sv
// rv32imac_lsu: load/store unit bridging core requests to a granted, single-beat memory bus.
// Define LSU_MISALIGNED_EN to split boundary-crossing accesses into two beats; otherwise misaligned accesses fault.
package rv32imac_lsu_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2, FENCE = 2'd3} mem_op_t;
endpackage

module rv32imac_lsu
  import rv32imac_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OW  = $clog2(NB);
  localparam int unsigned NB2 = 2 * NB;
  localparam int unsigned XL2 = 2 * XLEN;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            r_state;
  logic              r_mem_req, r_mem_we, r_rsp_valid, r_rsp_err;
  logic [AW-1:0]     r_mem_addr;
  logic [NB-1:0]     r_mem_be, r_be_hi;
  logic [XLEN-1:0]   r_mem_wdata, r_wd_hi, r_rd0, r_rsp_rdata;
  logic [OW-1:0]     r_off;
  logic [3:0]        r_size;
  logic              r_uns, r_load, r_split;

  logic [3:0]        w_size, w_offx;
  logic              w_err, w_split;
  logic [NB2-1:0]    w_be_full;
  logic [XLEN-1:0]   w_wmask;
  logic [XL2-1:0]    w_wfull;
  logic [AW-1:0]     w_base;
  logic [XL2-1:0]    w_pair;
  logic [XLEN-1:0]   w_ld;
  logic              w_sign;

  // Both beats' lanes are computed up front as one double-width window shifted by the byte offset.
  always_comb begin
    w_size    = 4'd1 << req_width;
    w_offx    = 4'(req_addr[OW-1:0]);
    w_be_full = NB2'((16'd1 << w_size) - 16'd1) << w_offx;
    w_wmask   = '0;
    for (int unsigned i = 0; i < NB; i++)
      if (i < 32'(w_size)) w_wmask[8*i +: 8] = 8'hFF;
    w_wfull   = {{XLEN{1'b0}}, req_wdata & w_wmask} << {w_offx, 3'b000};
    w_base    = {req_addr[AW-1:OW], {OW{1'b0}}};
`ifdef LSU_MISALIGNED_EN
    w_err     = (XLEN == 32) && (req_width == 2'd3);
    w_split   = (5'(w_offx) + 5'(w_size)) > 5'(NB);
`else
    w_err     = ((XLEN == 32) && (req_width == 2'd3)) ||
                ((w_offx & (w_size - 4'd1)) != 4'd0);
    w_split   = 1'b0;
`endif
  end

  always_comb begin
    w_pair = (r_state == WAIT1) ? {mem_rdata, r_rd0} : {{XLEN{1'b0}}, mem_rdata};
    w_ld   = XLEN'(w_pair >> {r_off, 3'b000});
    w_sign = 1'b0;
    for (int unsigned i = 0; i < NB; i++)
      if (i + 1 == 32'(r_size)) w_sign = w_ld[8*i+7] & ~r_uns;
    for (int unsigned i = 0; i < NB; i++)
      if (i >= 32'(r_size)) w_ld[8*i +: 8] = {8{w_sign}};
    if (!r_load) w_ld = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_be_hi     <= '0;
      r_wd_hi     <= '0;
      r_rd0       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_off       <= '0;
      r_size      <= 4'd1;
      r_uns       <= 1'b0;
      r_load      <= 1'b0;
      r_split     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          if ((req_op == LOAD || req_op == STORE) && !w_err) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (req_op == STORE);
            r_mem_addr  <= w_base;
            r_mem_be    <= w_be_full[NB-1:0];
            r_mem_wdata <= w_wfull[XLEN-1:0];
            r_be_hi     <= w_be_full[NB2-1:NB];
            r_wd_hi     <= w_wfull[XL2-1:XLEN];
            r_off       <= req_addr[OW-1:0];
            r_size      <= w_size;
            r_uns       <= req_unsigned;
            r_load      <= (req_op == LOAD);
            r_split     <= w_split;
            r_state     <= REQ0;
          end else begin
            r_rsp_err   <= (req_op == LOAD || req_op == STORE);
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        REQ0: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
          if (r_split) begin
            r_rd0       <= mem_rdata;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_mem_addr + AW'(NB);
            r_mem_be    <= r_be_hi;
            r_mem_wdata <= r_wd_hi;
            r_state     <= REQ1;
          end else begin
            r_rsp_rdata <= w_ld;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        REQ1: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          r_rsp_rdata <= w_ld;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_rv32imac_lsu.sv
// tb_rv32imac_lsu: directed and randomized checks of rv32imac_lsu (XLEN=32) against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_rv32imac_lsu;
  import rv32imac_lsu_pkg::*;

`ifdef LSU_MISALIGNED_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_unsigned;
  mem_op_t     req_op;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  rv32imac_lsu #(.XLEN(32), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [7:0]  mem_b [0:4095];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem_b[int'((a + 3) & 32'hFFF)], mem_b[int'((a + 2) & 32'hFFF)],
            mem_b[int'((a + 1) & 32'hFFF)], mem_b[int'(a & 32'hFFF)]};
  endfunction

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    for (int j = 0; j < 4; j++) mem_b[int'((a + 32'(j)) & 32'hFFF)] = d[8*j +: 8];
  endtask

  // One request end to end: expectations come from per-byte reasoning about the access.
  task automatic run_txn(input string tag, input mem_op_t op, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int gdly,
                         input bit has_lit, input logic [31:0] lit);
    int size, nb, k, b, cyc, lat_exp, beat, gd, rd;
    bit bus, err, in_req, waiting, done;
    logic [31:0] eaddr [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] erd, h_addr, h_wd;
    logic [3:0]  h_be;
    logic        h_we;
    size = 1 << w;
    bus  = (op == LOAD || op == STORE);
    err  = bus && (w == 2'd3 || (!MIS && (a % size) != 0));
    if (err) bus = 0;
    eaddr[0] = a & ~32'h3; eaddr[1] = eaddr[0] + 4;
    ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
    nb = 0; erd = '0;
    if (bus) begin
      for (int j = 0; j < size; j++) begin
        b = int'(a) + j;
        k = ((b >> 2) != int'(a >> 2)) ? 1 : 0;
        ebe[k][b % 4] = 1'b1;
        ewd[k][8*(b % 4) +: 8] = wd[8*j +: 8];
        if (k + 1 > nb) nb = k + 1;
        if (op == LOAD) erd[8*j +: 8] = mem_b[b & 4095];
      end
      if (op == LOAD && !u && erd[8*size-1]) erd = erd | 32'(~((64'h1 << (8*size)) - 64'h1));
    end

    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_width = w; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_op = NONE; req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; lat_exp = 1; beat = 0; in_req = 0; waiting = 0; done = 0;
    gd = 0; rd = 0; h_addr = '0; h_be = '0; h_wd = '0; h_we = 1'b0;
    while (!done && cyc < 300) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid) begin
        done = 1;
        chk({tag, ".latency"}, cyc, lat_exp);
        chk({tag, ".err"}, rsp_err, err);
        chk({tag, ".rdata"}, rsp_rdata, erd);
        chk({tag, ".beats"}, beat, nb);
        if (has_lit) chk({tag, ".rdata_lit"}, rsp_rdata, lit);
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
      end else if (mem_req) begin
        if (!in_req) begin
          chk({tag, ".beat_expected"}, beat < nb, 1);
          if (beat < 2) begin
            chk({tag, ".addr"}, mem_addr, eaddr[beat]);
            chk({tag, ".be"}, mem_be, ebe[beat]);
            chk({tag, ".we"}, mem_we, op == STORE);
            if (op == STORE) chk({tag, ".wdata"}, mem_wdata & {{8{ebe[beat][3]}}, {8{ebe[beat][2]}},
                                 {8{ebe[beat][1]}}, {8{ebe[beat][0]}}}, ewd[beat]);
          end
          h_addr = mem_addr; h_be = mem_be; h_wd = mem_wdata; h_we = mem_we;
          in_req = 1;
          gd = (gdly >= 0) ? gdly : int'($urandom_range(0, 3));
          lat_exp += gd + 1;
        end else begin
          chk({tag, ".hold"}, {mem_we, mem_be, mem_addr, mem_wdata}, {h_we, h_be, h_addr, h_wd});
        end
        if (gd == 0) begin
          mem_gnt = 1'b1; in_req = 0; waiting = 1;
          rd = (gdly >= 0) ? 0 : int'($urandom_range(0, 3));
          lat_exp += rd + 1;
        end else gd--;
      end else if (waiting) begin
        if (rd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_word(h_addr);
          if (h_we)
            for (int j = 0; j < 4; j++)
              if (h_be[j]) mem_b[int'((h_addr + 32'(j)) & 32'hFFF)] = h_wd[8*j +: 8];
          waiting = 0; beat++;
        end else rd--;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".completed"}, done, 1);
    chk({tag, ".one_pulse"}, rsp_valid, 0);
    chk({tag, ".back_idle"}, req_ready, 1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    mem_op_t    op;
    logic [1:0] w;
    int         r, size;
    logic [31:0] a, wd;
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
    rst_n = 1'b0; req_valid = 1'b0; req_op = NONE; req_width = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("reset.ready", req_ready, 1);
    chk("reset.ctl", {mem_req, mem_we, mem_be, rsp_valid, rsp_err}, '0);
    chk("reset.data", {mem_addr, mem_wdata}, '0);
    chk("reset.rdata", rsp_rdata, '0);
    @(negedge clk); rst_n = 1'b1;

    wr_word(32'h100, 32'hDEADBEEF);
    run_txn("ld_word", LOAD, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    wr_word(32'h100, 32'h80112233);
    run_txn("ld_byte_s", LOAD, 2'd0, 1'b0, 32'h103, 32'h0, -1, 1, 32'hFFFFFF80);
    run_txn("ld_byte_u", LOAD, 2'd0, 1'b1, 32'h103, 32'h0, -1, 1, 32'h00000080);
    run_txn("st_half", STORE, 2'd1, 1'b0, 32'h102, 32'h1234, 4, 1, 32'h0);
    chk("st_half.mem", rd_word(32'h100), 32'h12342233);
    wr_word(32'h0FC, 32'hAABBCCDD);
    wr_word(32'h100, 32'h11223344);
    run_txn("ld_split", LOAD, 2'd2, 1'b0, 32'h0FE, 32'h0, 0, 1, MIS ? 32'h3344AABB : 32'h0);
    run_txn("st_split", STORE, 2'd2, 1'b0, 32'h1FF, 32'hCAFEF00D, -1, 0, 32'h0);
    run_txn("ld_double", LOAD, 2'd3, 1'b0, 32'h200, 32'h0, -1, 1, 32'h0);
    run_txn("fence", FENCE, 2'd0, 1'b0, 32'h0, 32'h0, -1, 1, 32'h0);
    run_txn("none", NONE, 2'd2, 1'b0, 32'h40, 32'h0, -1, 1, 32'h0);

    for (int t = 0; t < 60; t++) begin
      r  = int'($urandom_range(0, 9));
      op = (r == 0) ? NONE : (r == 1) ? FENCE : (r < 6) ? LOAD : STORE;
      w  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      size = 1 << w;
      a  = $urandom_range(0, 4000);
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(size) - 1);
      wd = (size >= 4) ? $urandom : ($urandom & ((32'h1 << (8*size)) - 1));
      run_txn("rand", op, w, 1'($urandom_range(0, 1)), a, wd, -1, 0, 32'h0);
    end

    // Reset while waiting for read data: transaction abandoned, stray rvalid ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = LOAD; req_width = 2'd2; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.req0", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_mid.wait0", {mem_req, req_ready}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.ready", req_ready, 1);
    chk("rst_mid.ctl", {mem_req, mem_be, rsp_valid, rsp_err}, '0);
    chk("rst_mid.addr", mem_addr, '0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid.no_rsp", {rsp_valid, req_ready, mem_req}, 3'b010);
      @(negedge clk);
    end
    run_txn("post_rst", LOAD, 2'd1, 1'b1, 32'h302, 32'h0, -1, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
